// File: rtl/pc_ctrl_pkg.sv
// ============================================================================
// Module   : pc_ctrl_pkg
// Purpose  : Shared encodings for the PC sequencer: PC modes, op codes,
//            fault codes and sequencer states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_ctrl_pkg;

   localparam logic [1:0] C_MODE_STEP = 2'b00;
   localparam logic [1:0] C_MODE_LOAD = 2'b01;
   localparam logic [1:0] C_MODE_POP  = 2'b10;
   localparam logic [1:0] C_MODE_PUSH = 2'b11;

   localparam logic [2:0] C_OP_NOP  = 3'b000;
   localparam logic [2:0] C_OP_JMP  = 3'b001;
   localparam logic [2:0] C_OP_JZ   = 3'b010;
   localparam logic [2:0] C_OP_JC   = 3'b011;
   localparam logic [2:0] C_OP_CALL = 3'b100;
   localparam logic [2:0] C_OP_RET  = 3'b101;
   localparam logic [2:0] C_OP_HALT = 3'b110;
   localparam logic [2:0] C_OP_RSVD = 3'b111;

   localparam logic [1:0] C_FLT_NONE      = 2'b00;
   localparam logic [1:0] C_FLT_OVERFLOW  = 2'b01;
   localparam logic [1:0] C_FLT_UNDERFLOW = 2'b10;
   localparam logic [1:0] C_FLT_TIMEOUT   = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_EXEC   = 3'd1,
      ST_UPDATE = 3'd2,
      ST_HALT   = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_branch_eval.sv
// ============================================================================
// Module   : pc_branch_eval
// Purpose  : Combinational op decode: PC mode and whether control transfers
//            to the op target (unconditional, call, or condition met).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_branch_eval
   import pc_ctrl_pkg::*;
(
   input  logic [2:0] op_code,
   input  logic       flag_z,
   input  logic       flag_c,
   output logic       taken,
   output logic [1:0] mode
);

   always_comb begin
      taken = 1'b0;
      mode  = C_MODE_STEP;
      case (op_code)
         C_OP_JMP: begin
            taken = 1'b1;
            mode  = C_MODE_LOAD;
         end
         C_OP_JZ: begin
            taken = flag_z;
            mode  = flag_z ? C_MODE_LOAD : C_MODE_STEP;
         end
         C_OP_JC: begin
            taken = flag_c;
            mode  = flag_c ? C_MODE_LOAD : C_MODE_STEP;
         end
         C_OP_CALL: begin
            taken = 1'b1;
            mode  = C_MODE_PUSH;
         end
         C_OP_RET: begin
            mode  = C_MODE_POP;
         end
         default: begin
            taken = 1'b0;
            mode  = C_MODE_STEP;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/execute/update control FSM driving the 8-bit program
//            counter, with call-depth tracking and fault trapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
   import pc_ctrl_pkg::*;
#(
   parameter int STACK_DEPTH   = 32,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pc_value,
   output logic [1:0] pc_mode,
   output logic [7:0] pc_target,
   output logic       pc_en_a,
   output logic       mem_req,
   input  logic       mem_ack,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [2:0] op_code,
   input  logic [7:0] op_target,
   input  logic       flag_z,
   input  logic       flag_c,
   input  logic       resume,
   output logic       halted,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [5:0] depth
);

   localparam logic [5:0] C_DEPTH_MAX = 6'(STACK_DEPTH);
   localparam logic [3:0] C_TMO_LAST  = 4'(FETCH_TIMEOUT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_depth;
   logic [3:0] r_tmo;
   logic [1:0] r_fault_code;
   logic [1:0] w_fault_code;
   logic [2:0] r_op;
   logic [7:0] r_target;
   logic [1:0] r_mode;
   logic       r_taken;
   logic       w_br_taken;
   logic [1:0] w_br_mode;

   pc_branch_eval u_branch_eval (
      .op_code (op_code),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .taken   (w_br_taken),
      .mode    (w_br_mode)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_fault_code = r_fault_code;
      pc_mode      = C_MODE_LOAD;
      pc_target    = pc_value;
      pc_en_a      = 1'b0;
      mem_req      = 1'b0;
      op_ready     = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_req = 1'b1;
            pc_en_a = 1'b1;
            // An acknowledge on the last allowed cycle still wins over the timeout.
            if (mem_ack) begin
               w_next = ST_EXEC;
            end else if (r_tmo == C_TMO_LAST) begin
               w_next       = ST_FAULT;
               w_fault_code = C_FLT_TIMEOUT;
            end
         end
         ST_EXEC: begin
            op_ready = 1'b1;
            if (op_valid) begin
               w_next = ST_UPDATE;
               if (op_code == C_OP_HALT) begin
                  w_next = ST_HALT;
               end else if (op_code == C_OP_CALL && r_depth == C_DEPTH_MAX) begin
                  w_next       = ST_FAULT;
                  w_fault_code = C_FLT_OVERFLOW;
               end else if (op_code == C_OP_RET && r_depth == 6'd0) begin
                  w_next       = ST_FAULT;
                  w_fault_code = C_FLT_UNDERFLOW;
               end
            end
         end
         ST_UPDATE: begin
            pc_mode   = r_mode;
            pc_target = r_taken ? r_target : pc_value;
            w_next    = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (resume) w_next = ST_UPDATE;
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            w_next = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_depth      <= 6'd0;
         r_tmo        <= 4'd0;
         r_fault_code <= C_FLT_NONE;
         r_op         <= C_OP_NOP;
         r_target     <= 8'd0;
         r_mode       <= C_MODE_STEP;
         r_taken      <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: r_tmo <= mem_ack ? 4'd0 : r_tmo + 4'd1;
            ST_EXEC: begin
               if (op_valid) begin
                  r_op     <= op_code;
                  r_target <= op_target;
                  r_mode   <= w_br_mode;
                  r_taken  <= w_br_taken;
               end
            end
            ST_UPDATE: begin
               if (r_op == C_OP_CALL)     r_depth <= r_depth + 6'd1;
               else if (r_op == C_OP_RET) r_depth <= r_depth - 6'd1;
            end
            ST_HALT: begin
               // Leaving HALT replays as a NOP so the PC steps past the halt.
               if (resume) begin
                  r_op    <= C_OP_NOP;
                  r_mode  <= C_MODE_STEP;
                  r_taken <= 1'b0;
               end
            end
            default: ;
         endcase
         if (w_next == ST_FAULT && r_state != ST_FAULT) r_fault_code <= w_fault_code;
      end
   end

   assign fault_code = r_fault_code;
   assign depth      = r_depth;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with a behavioural PC,
//            a program-level reference model and randomized op streams.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JC = 3'd3;
   localparam logic [2:0] CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSVD = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pc_value;
   logic [1:0] pc_mode;
   logic [7:0] pc_target;
   logic       pc_en_a, mem_req, op_ready, halted, fault;
   logic       mem_ack = 1'b0, op_valid = 1'b0, resume = 1'b0;
   logic       flag_z = 1'b0, flag_c = 1'b0;
   logic [2:0] op_code = 3'd0;
   logic [7:0] op_target = 8'd0;
   logic [1:0] fault_code;
   logic [5:0] depth;

   int errors = 0;
   int checks = 0;

   // Program-level reference: where the program should be, not how the FSM gets there.
   logic [7:0] mpc;
   int         mdepth;
   logic [7:0] mstack[$];

   // Behavioural program counter with its 32-entry return stack.
   logic [7:0] emu_stack[32];
   int         emu_sp;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .pc_value(pc_value), .pc_mode(pc_mode),
      .pc_target(pc_target), .pc_en_a(pc_en_a), .mem_req(mem_req),
      .mem_ack(mem_ack), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_target(op_target), .flag_z(flag_z),
      .flag_c(flag_c), .resume(resume), .halted(halted), .fault(fault),
      .fault_code(fault_code), .depth(depth)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         pc_value <= 8'd0;
         emu_sp   <= 0;
      end else begin
         case (pc_mode)
            2'b00: pc_value <= pc_value + 8'd1;
            2'b01: pc_value <= pc_target;
            2'b10: begin
               if (emu_sp > 0) begin
                  pc_value <= emu_stack[emu_sp-1];
                  emu_sp   <= emu_sp - 1;
               end
            end
            default: begin
               if (emu_sp < 32) begin
                  emu_stack[emu_sp] <= pc_value + 8'd1;
                  emu_sp            <= emu_sp + 1;
               end
               pc_value <= pc_target;
            end
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      rst = 1'b1; mem_ack = 1'b0; op_valid = 1'b0; resume = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mpc = 8'd0; mdepth = 0; mstack.delete();
   endtask

   // Hold mem_ack low for dly FETCH cycles, then acknowledge.
   task automatic fetch(input int dly);
      for (int i = 0; i < dly; i++) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   task automatic drive_op(input logic [2:0] code, input logic [7:0] t, input logic z, input logic c);
      op_code = code; op_target = t; flag_z = z; flag_c = c; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      flag_z = $urandom_range(0, 1); flag_c = $urandom_range(0, 1);
   endtask

   // Full op: fetch, accept, sample the UPDATE cycle, finish back in FETCH.
   task automatic run_op(input logic [2:0] code, input logic [7:0] t, input logic z, input logic c,
                         input int dly, output logic [1:0] um, output logic [7:0] ut);
      fetch(dly);
      drive_op(code, t, z, c);
      um = pc_mode;
      ut = pc_target;
      @(negedge clk);
   endtask

   task automatic model_apply(input logic [2:0] code, input logic [7:0] t, input logic z, input logic c);
      case (code)
         JMP:  mpc = t;
         JZ:   mpc = z ? t : mpc + 8'd1;
         JC:   mpc = c ? t : mpc + 8'd1;
         CALL: begin mstack.push_back(mpc + 8'd1); mdepth++; mpc = t; end
         RET:  begin mpc = mstack.pop_back(); mdepth--; end
         default: mpc = mpc + 8'd1;
      endcase
   endtask

   function automatic logic [1:0] spec_mode(input logic [2:0] code, input logic z, input logic c);
      if (code == JMP) return 2'b01;
      if (code == JZ)  return z ? 2'b01 : 2'b00;
      if (code == JC)  return c ? 2'b01 : 2'b00;
      if (code == CALL) return 2'b11;
      if (code == RET) return 2'b10;
      return 2'b00;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_req, pc_en_a, op_ready, halted, fault} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_ctrl: req/en/rdy/halt/flt=%b want 11000", {mem_req, pc_en_a, op_ready, halted, fault});
      end
      checks++;
      if (fault_code !== 2'b00 || depth !== 6'd0) begin
         errors++;
         $display("FAIL reset_state: fault_code=%b depth=%0d want 00 0", fault_code, depth);
      end
      checks++;
      if (pc_mode !== 2'b01 || pc_target !== 8'h00) begin
         errors++;
         $display("FAIL reset_hold: mode=%b target=%h want 01 00", pc_mode, pc_target);
      end
   endtask

   task automatic test_nop();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (mem_req !== 1'b1 || pc_mode !== 2'b01 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL nop_fetch_wait%0d: req=%b mode=%b rdy=%b want 1 01 0", i, mem_req, pc_mode, op_ready);
         end
         @(negedge clk);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (op_ready !== 1'b1 || mem_req !== 1'b0 || pc_mode !== 2'b01) begin
         errors++;
         $display("FAIL nop_exec: rdy=%b req=%b mode=%b want 1 0 01", op_ready, mem_req, pc_mode);
      end
      drive_op(NOP, 8'hAA, 1'b1, 1'b1);
      checks++;
      if (pc_mode !== 2'b00) begin
         errors++;
         $display("FAIL nop_update_mode: got %b want 00", pc_mode);
      end
      @(negedge clk);
      model_apply(NOP, 8'hAA, 1'b1, 1'b1);
      checks++;
      if (pc_value !== mpc || mem_req !== 1'b1 || pc_mode !== 2'b01) begin
         errors++;
         $display("FAIL nop_after: pc=%h req=%b mode=%b want %h 1 01", pc_value, mem_req, pc_mode, mpc);
      end
   endtask

   task automatic test_jz();
      logic [1:0] um;
      logic [7:0] ut;
      do_reset();
      run_op(JZ, 8'h40, 1'b1, 1'b0, 1, um, ut);
      model_apply(JZ, 8'h40, 1'b1, 1'b0);
      checks++;
      if (um !== 2'b01 || ut !== 8'h40 || pc_value !== mpc) begin
         errors++;
         $display("FAIL jz_taken: mode=%b target=%h pc=%h want 01 40 %h", um, ut, pc_value, mpc);
      end
      run_op(JZ, 8'h80, 1'b0, 1'b1, 0, um, ut);
      model_apply(JZ, 8'h80, 1'b0, 1'b1);
      checks++;
      if (um !== 2'b00 || pc_value !== mpc) begin
         errors++;
         $display("FAIL jz_not_taken: mode=%b pc=%h want 00 %h", um, pc_value, mpc);
      end
      run_op(JC, 8'h33, 1'b0, 1'b1, 2, um, ut);
      model_apply(JC, 8'h33, 1'b0, 1'b1);
      checks++;
      if (um !== 2'b01 || pc_value !== mpc) begin
         errors++;
         $display("FAIL jc_taken: mode=%b pc=%h want 01 %h", um, pc_value, mpc);
      end
   endtask

   task automatic test_call_ret();
      logic [1:0] um;
      logic [7:0] ut;
      do_reset();
      run_op(JMP, 8'h10, 1'b0, 1'b0, 0, um, ut);
      model_apply(JMP, 8'h10, 1'b0, 1'b0);
      run_op(CALL, 8'h20, 1'b0, 1'b0, 1, um, ut);
      model_apply(CALL, 8'h20, 1'b0, 1'b0);
      checks++;
      if (um !== 2'b11 || ut !== 8'h20 || pc_value !== mpc || depth !== 6'(mdepth)) begin
         errors++;
         $display("FAIL call: mode=%b target=%h pc=%h depth=%0d want 11 20 %h %0d", um, ut, pc_value, depth, mpc, mdepth);
      end
      run_op(RET, 8'h77, 1'b0, 1'b0, 0, um, ut);
      model_apply(RET, 8'h77, 1'b0, 1'b0);
      checks++;
      if (um !== 2'b10 || pc_value !== mpc || depth !== 6'(mdepth)) begin
         errors++;
         $display("FAIL ret: mode=%b pc=%h depth=%0d want 10 %h %0d", um, pc_value, depth, mpc, mdepth);
      end
   endtask

   task automatic test_overflow();
      logic [1:0] um;
      logic [7:0] ut;
      logic [7:0] t;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         t = 8'($urandom);
         run_op(CALL, t, 1'b0, 1'b0, 0, um, ut);
         model_apply(CALL, t, 1'b0, 1'b0);
      end
      checks++;
      if (depth !== 6'd32 || pc_value !== mpc) begin
         errors++;
         $display("FAIL ovf_fill: depth=%0d pc=%h want 32 %h", depth, pc_value, mpc);
      end
      fetch(0);
      drive_op(CALL, 8'h5A, 1'b0, 1'b0);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b01 || depth !== 6'd32 || pc_mode !== 2'b01) begin
         errors++;
         $display("FAIL ovf_trap: fault=%b code=%b depth=%0d mode=%b want 1 01 32 01", fault, fault_code, depth, pc_mode);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b01 || pc_value !== mpc || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky: fault=%b code=%b pc=%h req=%b want 1 01 %h 0", fault, fault_code, pc_value, mpc, mem_req);
      end
      do_reset();
      checks++;
      if (depth !== 6'd0 || fault !== 1'b0 || fault_code !== 2'b00 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL ovf_reset: depth=%0d fault=%b code=%b req=%b want 0 0 00 1", depth, fault, fault_code, mem_req);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      fetch(1);
      drive_op(RET, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b10 || depth !== 6'd0 || pc_value !== mpc) begin
         errors++;
         $display("FAIL underflow: fault=%b code=%b depth=%0d pc=%h want 1 10 0 %h", fault, fault_code, depth, pc_value, mpc);
      end
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b1 || fault !== 1'b0 || pc_mode !== 2'b01) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tmo_wait: %0d bad cycles in first 14, want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b11 || pc_mode !== 2'b01 || pc_value !== 8'h00) begin
         errors++;
         $display("FAIL tmo_trap: fault=%b code=%b mode=%b pc=%h want 1 11 01 00", fault, fault_code, pc_mode, pc_value);
      end
      do_reset();
      repeat (14) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (op_ready !== 1'b1 || fault !== 1'b0) begin
         errors++;
         $display("FAIL tmo_ack_wins: rdy=%b fault=%b want 1 0", op_ready, fault);
      end
   endtask

   task automatic test_halt();
      int bad;
      do_reset();
      fetch(0);
      drive_op(HALT, 8'h99, 1'b1, 1'b1);
      checks++;
      if (halted !== 1'b1 || pc_mode !== 2'b01) begin
         errors++;
         $display("FAIL halt_enter: halted=%b mode=%b want 1 01", halted, pc_mode);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (halted !== 1'b1 || pc_mode !== 2'b01 || pc_value !== mpc) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: %0d bad cycles of 10, want 0", bad);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      checks++;
      if (pc_mode !== 2'b00 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_resume: mode=%b halted=%b want 00 0", pc_mode, halted);
      end
      @(negedge clk);
      model_apply(NOP, 8'h00, 1'b0, 1'b0);
      checks++;
      if (pc_value !== mpc || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL halt_step: pc=%h req=%b want %h 1", pc_value, mem_req, mpc);
      end
      fetch(0);
      drive_op(HALT, 8'h00, 1'b0, 1'b0);
      resume = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      resume = 1'b0;
      mpc = 8'd0; mdepth = 0; mstack.delete();
      checks++;
      if (mem_req !== 1'b1 || halted !== 1'b0 || pc_mode !== 2'b01 || pc_value !== mpc) begin
         errors++;
         $display("FAIL halt_rst_wins: req=%b halted=%b mode=%b pc=%h want 1 0 01 %h", mem_req, halted, pc_mode, pc_value, mpc);
      end
   endtask

   task automatic test_random();
      logic [2:0] code;
      logic [7:0] t;
      logic       z, c;
      logic [1:0] um, em;
      logic [7:0] ut;
      int         pick;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 6);
         code = (pick == 6) ? RSVD : 3'(pick);
         if (code == CALL && mdepth == 32) code = NOP;
         if (code == RET && mdepth == 0) code = CALL;
         t = 8'($urandom);
         z = $urandom_range(0, 1);
         c = $urandom_range(0, 1);
         em = spec_mode(code, z, c);
         run_op(code, t, z, c, $urandom_range(0, 4), um, ut);
         model_apply(code, t, z, c);
         checks++;
         if (um !== em || pc_value !== mpc || depth !== 6'(mdepth)) begin
            errors++;
            $display("FAIL rand_op%0d code=%0d: mode=%b pc=%h depth=%0d want %b %h %0d",
                     n, code, um, pc_value, depth, em, mpc, mdepth);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_jz();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_timeout();
      test_halt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
